hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage CPU.
- Drives the IF/ID register's write-enable (wpcir) and flush (Condep), the ID/EX bubble, and the EX operand forwarding selects.
- Tracks the multi-cycle multiply/divide unit (MDU) with a busy counter and stalls only dependent instructions.
- Sits beside the ID stage; all hazard decisions are made here.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/fwd_sel.sv | 29 ++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects,
// controller state encoding and the hard-wired zero register.
package hazard_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    // True when a writer's destination is a real register equal to the source.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID source register (instanced for rs and rt).
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [4:0] ex_rd,
    input  logic       ex_wreg,
    input  logic [4:0] mem_rd,
    input  logic       mem_wreg,
    input  logic       mem_mem2reg,
    output logic [1:0] sel
);

    // Youngest producer wins; a MEM-stage load hands over its load data.
    always_comb begin
        sel = FWD_RF;
        if (!use_src) begin
            sel = FWD_RF;
        end else if (ex_wreg && reg_hit(ex_rd, src)) begin
            sel = FWD_EXALU;
        end else if (mem_wreg && reg_hit(mem_rd, src)) begin
            sel = mem_mem2reg ? FWD_MEMLD : FWD_MEMALU;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller beside the ID stage: load-use and MDU stalls,
// branch flush, EX forwarding selects. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic [4:0] EX_Rd,
    input  logic       EX_Wreg,
    input  logic       EX_Mem2Reg,
    input  logic [4:0] MEM_Rd,
    input  logic       MEM_Wreg,
    input  logic       MEM_Mem2Reg,
    input  logic       ID_Branch,
    input  logic       ID_MduStart,
    input  logic       ID_MduUse,
    output logic       wpcir,
    output logic       Condep,
    output logic       ID_Bubble,
    output logic [1:0] FwdA,
    output logic [1:0] FwdB,
    output logic       MduBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ldh_s;
    logic             mdh_s;
    logic             stall_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    fwd_sel u_fwd_rs (
        .src         (ID_Rs),
        .use_src     (ID_UseRs),
        .ex_rd       (EX_Rd),
        .ex_wreg     (EX_Wreg),
        .mem_rd      (MEM_Rd),
        .mem_wreg    (MEM_Wreg),
        .mem_mem2reg (MEM_Mem2Reg),
        .sel         (fwd_a_s)
    );

    fwd_sel u_fwd_rt (
        .src         (ID_Rt),
        .use_src     (ID_UseRt),
        .ex_rd       (EX_Rd),
        .ex_wreg     (EX_Wreg),
        .mem_rd      (MEM_Rd),
        .mem_wreg    (MEM_Wreg),
        .mem_mem2reg (MEM_Mem2Reg),
        .sel         (fwd_b_s)
    );

    // Hazard detection: a load in EX feeding ID, or any MDU access while busy.
    always_comb begin
        ldh_s = EX_Wreg && EX_Mem2Reg && (EX_Rd != REG_ZERO) &&
                ((ID_UseRs && (EX_Rd == ID_Rs)) || (ID_UseRt && (EX_Rd == ID_Rt)));
        mdh_s = (state_r == ST_MDU) && (ID_MduUse || ID_MduStart);
        stall_s = ldh_s || mdh_s;
    end

    // Pipeline controls; reset forces a flush/bubble so nothing stale retires.
    always_comb begin
        wpcir     = 1'b1;
        Condep    = 1'b1;
        ID_Bubble = 1'b1;
        FwdA      = FWD_RF;
        FwdB      = FWD_RF;
        MduBusy   = 1'b0;
        if (Clr) begin
            wpcir     = 1'b1;
            Condep    = 1'b1;
            ID_Bubble = 1'b1;
            FwdA      = FWD_RF;
            FwdB      = FWD_RF;
            MduBusy   = 1'b0;
        end else begin
            wpcir     = !stall_s;
            Condep    = ID_Branch && !stall_s;
            ID_Bubble = stall_s;
            FwdA      = fwd_a_s;
            FwdB      = fwd_b_s;
            MduBusy   = (state_r == ST_MDU);
        end
    end

    // MDU sequencer: count down the latency, return to RUN after the cnt==0 cycle.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ID_MduStart && !stall_s) begin
                        state_r <= ST_MDU;
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        state_r <= ST_RUN;
                        cnt_r   <= '0;
                    end
                end
                ST_MDU: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_MDU;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (Condep && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each step pushes its expected controls,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       clr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] ex_rd;
        logic       ex_wreg;
        logic       ex_m2r;
        logic [4:0] mem_rd;
        logic       mem_wreg;
        logic       mem_m2r;
        logic       br;
        logic       mstart;
        logic       muse;
    } stim_t;

    typedef struct packed {
        logic       wpcir;
        logic       condep;
        logic       bubble;
        logic [1:0] fwda;
        logic [1:0] fwdb;
        logic       busy;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic [4:0] ID_Rs = 5'd0, ID_Rt = 5'd0, EX_Rd = 5'd0, MEM_Rd = 5'd0;
    logic       ID_UseRs = 1'b0, ID_UseRt = 1'b0;
    logic       EX_Wreg = 1'b0, EX_Mem2Reg = 1'b0, MEM_Wreg = 1'b0, MEM_Mem2Reg = 1'b0;
    logic       ID_Branch = 1'b0, ID_MduStart = 1'b0, ID_MduUse = 1'b0;
    logic       wpcir, Condep, ID_Bubble, MduBusy;
    logic [1:0] FwdA, FwdB;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UseRs    (ID_UseRs),
        .ID_UseRt    (ID_UseRt),
        .EX_Rd       (EX_Rd),
        .EX_Wreg     (EX_Wreg),
        .EX_Mem2Reg  (EX_Mem2Reg),
        .MEM_Rd      (MEM_Rd),
        .MEM_Wreg    (MEM_Wreg),
        .MEM_Mem2Reg (MEM_Mem2Reg),
        .ID_Branch   (ID_Branch),
        .ID_MduStart (ID_MduStart),
        .ID_MduUse   (ID_MduUse),
        .wpcir       (wpcir),
        .Condep      (Condep),
        .ID_Bubble   (ID_Bubble),
        .FwdA        (FwdA),
        .FwdB        (FwdB),
        .MduBusy     (MduBusy)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt    (StallCnt),
        .FlushCnt    (FlushCnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic w, input logic c, input logic b,
                                input logic [1:0] fa, input logic [1:0] fb, input logic busy);
        exp_t e;
        e.wpcir = w; e.condep = c; e.bubble = b; e.fwda = fa; e.fwdb = fb; e.busy = busy;
        return e;
    endfunction

    task automatic apply(input stim_t s, input exp_t e);
        @(posedge Clk);
        #1;
        Clr = s.clr; ID_Rs = s.rs; ID_Rt = s.rt; ID_UseRs = s.use_rs; ID_UseRt = s.use_rt;
        EX_Rd = s.ex_rd; EX_Wreg = s.ex_wreg; EX_Mem2Reg = s.ex_m2r;
        MEM_Rd = s.mem_rd; MEM_Wreg = s.mem_wreg; MEM_Mem2Reg = s.mem_m2r;
        ID_Branch = s.br; ID_MduStart = s.mstart; ID_MduUse = s.muse;
        exp_q.push_back(e);
    endtask

    // Monitor: compare popped expectations mid-cycle, away from the active edge.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("wpcir",     32'(wpcir),     32'(e.wpcir));
            check_eq("Condep",    32'(Condep),    32'(e.condep));
            check_eq("ID_Bubble", 32'(ID_Bubble), 32'(e.bubble));
            check_eq("FwdA",      32'(FwdA),      32'(e.fwda));
            check_eq("FwdB",      32'(FwdB),      32'(e.fwdb));
            check_eq("MduBusy",   32'(MduBusy),   32'(e.busy));
        end
    end

    initial begin
        stim_t s;
        stim_t ldh;

        ldh = '0;
        ldh.ex_rd = 5'd5; ldh.ex_wreg = 1'b1; ldh.ex_m2r = 1'b1;
        ldh.rs = 5'd5; ldh.use_rs = 1'b1;

        // Reset, then issue a mult and reset again while it is in flight.
        s = '0; s.clr = 1'b1;
        apply(s, mk(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0));
        s = '0; s.mstart = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        s = ldh; s.clr = 1'b1; s.muse = 1'b1;
        apply(s, mk(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0));
        apply(s, mk(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0));
        s = '0;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

        // Load-use: one stall cycle, then the load data forwards from MEM.
        apply(ldh, mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0));
        s = '0; s.rs = 5'd5; s.use_rs = 1'b1;
        s.mem_rd = 5'd5; s.mem_wreg = 1'b1; s.mem_m2r = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0));

        // Forwarding priority, register zero, MEM ALU path, unused source.
        s = '0; s.rt = 5'd7; s.use_rt = 1'b1;
        s.ex_rd = 5'd7; s.ex_wreg = 1'b1; s.mem_rd = 5'd7; s.mem_wreg = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0));
        s.rt = 5'd0; s.ex_rd = 5'd0; s.mem_rd = 5'd0;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        s = '0; s.rt = 5'd9; s.use_rt = 1'b1; s.mem_rd = 5'd9; s.mem_wreg = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0));
        s = '0; s.rs = 5'd3; s.ex_rd = 5'd3; s.ex_wreg = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

        // Branch vs stall: stall wins, branch flushes on the re-presentation.
        s = ldh; s.br = 1'b1;
        apply(s, mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0));
        s = '0; s.br = 1'b1; s.rs = 5'd5; s.use_rs = 1'b1;
        s.mem_rd = 5'd5; s.mem_wreg = 1'b1; s.mem_m2r = 1'b1;
        apply(s, mk(1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0));

        // MDU latency 4: mfhi stalls for four busy cycles, released on the fifth.
        s = '0; s.mstart = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        s = '0; s.muse = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(s, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
        end
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
`ifdef HAZARD_PERF_EN
        @(negedge Clk);
        #1;
        check_eq("StallCnt_a", StallCnt, 32'd6);
        check_eq("FlushCnt_a", FlushCnt, 32'd1);
`endif

        // Independent work proceeds under a busy MDU; a second mult stalls.
        s = '0; s.mstart = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        s = '0; s.rs = 5'd2; s.rt = 5'd3; s.use_rs = 1'b1; s.use_rt = 1'b1;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        s = '0; s.mstart = 1'b1;
        apply(s, mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1));
        s = '0;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1));
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));

`ifdef HAZARD_PERF_EN
        @(negedge Clk);
        #1;
        check_eq("StallCnt_b", StallCnt, 32'd7);
        check_eq("FlushCnt_b", FlushCnt, 32'd1);
        force dut.stall_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_r;
`endif
        apply(ldh, mk(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0));
        s = '0;
        apply(s, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
`ifdef HAZARD_PERF_EN
        @(negedge Clk);
        #1;
        check_eq("StallCnt_sat", StallCnt, 32'hFFFF_FFFF);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge Clk);
        end
        if (exp_q.size() > 0) begin
            check_eq("drain", 32'(exp_q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
